// File: rtl/mem_router.sv
// mem_router: routes one CPU memory port to NUM_SLAVES slaves decoded on addr[31:28], in-order reads.
// Optional MEM_ROUTER_DECODE_ERR_EN adds read_error/write_error decode-error reporting.
module mem_router #(
  parameter int NUM_SLAVES      = 4,
  parameter int BASE_REGION     = 1,
  parameter int MAX_OUTSTANDING = 4
) (
  input  logic                     clk,
  input  logic                     reset_n,
  output logic                     ready,
  input  logic [31:0]              addr,
  input  logic [31:0]              write_data,
  input  logic [3:0]               byte_enable,
  input  logic                     write_req,
  input  logic                     read_req,
  output logic [31:0]              read_data,
  output logic                     read_data_valid,
`ifdef MEM_ROUTER_DECODE_ERR_EN
  output logic                     read_error,
  output logic                     write_error,
`endif
  output logic [27:0]              s_addr,
  output logic [31:0]              s_write_data,
  output logic [3:0]               s_byte_enable,
  output logic [NUM_SLAVES-1:0]    s_write_req,
  output logic [NUM_SLAVES-1:0]    s_read_req,
  input  logic [NUM_SLAVES-1:0]    s_ready,
  input  logic [32*NUM_SLAVES-1:0] s_read_data,
  input  logic [NUM_SLAVES-1:0]    s_read_data_valid
);
  localparam int TW = $clog2(NUM_SLAVES + 1);
  localparam int CW = $clog2(MAX_OUTSTANDING + 1);
  localparam logic [TW-1:0] UNM = TW'(NUM_SLAVES);
`ifdef MEM_ROUTER_DECODE_ERR_EN
  localparam logic [31:0] UNM_DATA = 32'hBADADD00;
`else
  localparam logic [31:0] UNM_DATA = 32'h0;
`endif
  logic [CW-1:0] out_cnt;
  logic [TW-1:0] out_tgt, tgt;
  logic dummy_pend, hit, ret, gate, tgt_rdy, rd_acc;
  logic [4:0] diff;
  logic [31:0] sel_data;
  logic sel_valid;
  logic [NUM_SLAVES-1:0] one_hot;
  assign diff = {1'b0, addr[31:28]} - 5'(BASE_REGION);
  assign hit = ({1'b0, addr[31:28]} >= 5'(BASE_REGION)) && (diff < 5'(NUM_SLAVES));
  assign tgt = hit ? diff[TW-1:0] : UNM;
  assign one_hot = NUM_SLAVES'(1) << tgt;
  assign tgt_rdy = hit ? s_ready[tgt] : 1'b1;
  always_comb begin
    sel_data = '0;
    sel_valid = dummy_pend;
    for (int i = 0; i < NUM_SLAVES; i++)
      if (out_tgt == TW'(i)) begin
        sel_data = s_read_data[32*i +: 32];
        sel_valid = s_read_data_valid[i];
      end
  end
  assign ret = (out_cnt != '0) && sel_valid;
  // A return in the same cycle frees its slot, so a full or draining tracker can accept immediately.
  assign gate = (out_cnt != CW'(MAX_OUTSTANDING) || ret) && (out_cnt == CW'(ret) || tgt == out_tgt);
  assign ready = read_req ? tgt_rdy && gate : write_req ? tgt_rdy : 1'b1;
  assign rd_acc = read_req && ready;
  assign s_addr = addr[27:0];
  assign s_write_data = write_data;
  assign s_byte_enable = byte_enable;
  assign s_write_req = (write_req && hit) ? one_hot : '0;
  assign s_read_req = (read_req && hit && gate) ? one_hot : '0;
  assign read_data_valid = ret;
  assign read_data = !ret ? 32'h0 : (out_tgt == UNM) ? UNM_DATA : sel_data;
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      out_cnt <= '0;
      out_tgt <= UNM;
      dummy_pend <= 1'b0;
    end else begin
      out_cnt <= out_cnt + CW'(rd_acc) - CW'(ret);
      if (rd_acc) out_tgt <= tgt;
      dummy_pend <= rd_acc && !hit;
    end
`ifdef MEM_ROUTER_DECODE_ERR_EN
  assign read_error = ret && (out_tgt == UNM);
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) write_error <= 1'b0;
    else write_error <= write_req && ready && !hit;
`endif
endmodule

// File: doc/mem_router.md
Name: mem_router

Overview:
- Parametrised successor to the single-master address mapper: routes one CPU-side memory port to NUM_SLAVES memory-mapped slaves, decoded on addr[31:28].
- Adds per-slave backpressure, a bounded outstanding-read tracker and in-order read return. Unmapped accesses get a synthesised response.
- Sits between the CPU load/store unit and the program ROM, LED, UART and other peripheral interfaces.

Parameters:
NUM_SLAVES, 4, number of slave ports (1..15)
BASE_REGION, 1, addr[31:28] value mapped to slave 0; slave i at BASE_REGION+i
MAX_OUTSTANDING, 4, max reads in flight (power of two, >=1)

Ports:
clk  input  1  clock
reset_n  input  1  asynchronous, active-low reset
ready  output  1  request accepted this cycle if read_req|write_req
addr  input  32  byte address; [31:28] region, [27:0] slave offset
write_data  input  32  write data
byte_enable  input  4  write byte lanes
write_req  input  1  write request
read_req  input  1  read request (never together with write_req)
read_data  output  32  read return data
read_data_valid  output  1  read return strobe, one per accepted read
s_addr  output  28  addr[27:0], broadcast to all slaves
s_write_data  output  32  broadcast write_data
s_byte_enable  output  4  broadcast byte_enable
s_write_req  output  NUM_SLAVES  one-hot write request
s_read_req  output  NUM_SLAVES  one-hot read request
s_ready  input  NUM_SLAVES  per-slave accept
s_read_data  input  32*NUM_SLAVES  slave i data at [32i+31:32i]
s_read_data_valid  input  NUM_SLAVES  per-slave return strobe

Behaviour:
- Decode (combinational):
  - region r = addr[31:28]; hit when BASE_REGION <= r < BASE_REGION+NUM_SLAVES; sel = r-BASE_REGION.
  - On a miss the access is unmapped.
- Slave requests:
  - s_*_req[sel] = req & ready_gate; all other bits 0.
  - Reset value of all slave request bits is 0.
- Tracker state:
  - out_cnt (0..MAX_OUTSTANDING), out_tgt (slave index or UNMAPPED), dummy_pend.
  - All reset to 0 / UNMAPPED / 0.
- ready:
  - Write, mapped: s_ready[sel].
  - Write, unmapped: 1 (write dropped).
  - Read: target ready (unmapped counts as 1) AND out_cnt < MAX_OUTSTANDING AND (out_cnt==0 OR target==out_tgt).
  - Any read to a different target than out_tgt stalls until out_cnt drains to 0. This guarantees in-order return.
  - No request: ready = 1.
- Read accept:
  - out_tgt <= target; out_cnt increments.
  - Unmapped: the response is generated internally exactly 1 cycle later (dummy_pend pipeline).
- Return path:
  - When out_cnt>0 and s_read_data_valid[out_tgt]=1, forward that slave's data with read_data_valid=1; out_cnt decrements.
  - Unmapped returns drive read_data=0 with valid.
  - Valid strobes from non-target slaves, or any strobe while out_cnt==0, are ignored (not forwarded, no count change).
- Latency: zero added cycles on request and return paths (both combinational); unmapped read valid in cycle N+1.
- Simultaneous accept and return in the same cycle: out_cnt unchanged.
- Full: out_cnt==MAX_OUTSTANDING holds ready=0 for reads; writes are unaffected.
- Reset mid-operation:
  - All counters clear immediately.
  - Late slave returns after reset are dropped per the ignore rule.
- read_data = 0 whenever read_data_valid=0. Reset: ready=1 when idle, read_data_valid=0.

Optional Feature:
MEM_ROUTER_DECODE_ERR_EN
- Defined:
  - Adds output ports read_error (1) and write_error (1), both reset 0.
  - An unmapped read returns read_data=32'hBADADD00 with read_error=1 in the same cycle as read_data_valid.
  - An accepted unmapped write pulses write_error for 1 cycle, one cycle after acceptance.
- Undefined: the ports are absent; unmapped reads return 0 and unmapped writes are silently dropped.

Test Plan:
- NUM_SLAVES=4: read 0x2000_0010, slave1 ready, returns 0x1234_5678 three cycles later -> only s_read_req[1] high with s_addr=0x000_0010; read_data=0x1234_5678 with valid for exactly 1 cycle.
- Four back-to-back reads to slave0, slave withholding returns -> first four accepted, fifth sees ready=0; one return -> ready=1 again that cycle, count stays 4.
- Read slave0 outstanding, then read slave2 -> ready=0 until slave0 returns, then slave2 is issued; data order is slave0 then slave2.
- Read 0xF000_0000 (unmapped) -> ready=1, valid next cycle with read_data=0 (0xBADADD00 plus read_error=1 with MEM_ROUTER_DECODE_ERR_EN).
- Write 0x3000_0004 data 0xA5A5_0000 BE 4'b1100 with s_ready[2]=0 for 2 cycles -> ready low 2 cycles, s_write_req[2] held, accepted on cycle 3.
- Two reads outstanding, reset_n pulsed, then slave strobes valid -> no read_data_valid; ready=1 after reset.
